round_controller: RTL and testbench
===================================

# round_controller

Game-round sequencer that sits between the DE2 push-buttons and the countdown timer / seven-segment display path. It issues load and run commands to the timer and consumes the timer's `one_second_pulse` and `game_finished` outputs. Its responsibilities are to start a round, pause and resume it, detect the end of the round, flash a game-over indicator, and count completed rounds. The top level gates the display countdown with `timer_enable` and reloads the timer with `timer_load`/`load_value`.

## Interface
- `ROUND_SECONDS`, default 30: value driven on `load_value`, in binary seconds (range 1–99).
- `FLASH_SECONDS`, default 3: number of `one_second_pulse` periods that the OVER state lasts before it returns to IDLE (range 1–15).
- `SYNC_STAGES`, default 2: flip-flop stages in each key synchroniser (≥2).
- `clk`, input, 1: 50 MHz system clock.
- `rst`, input, 1: reset. Asynchronous and active-low.
- `key_start_n`, input, 1: raw KEY, active-low. KEYs are hardware-debounced.
- `key_pause_n`, input, 1: raw KEY, active-low.
- `one_second_pulse`, input, 1: one-cycle strobe from the countdown timer. It is free-running.
- `game_finished`, input, 1: level from the display timer, high when the count reaches 0.
- `timer_load`, output, 1: one-cycle strobe that reloads the countdown with `load_value`.
- `load_value`, output, 7: constant `ROUND_SECONDS`.
- `timer_enable`, output, 1: when high, the countdown consumes `one_second_pulse`.
- `game_active`, output, 1: high in RUNNING or PAUSED.
- `game_over_led`, output, 1: flashes in the OVER state.
- `round_count`, output, 4: number of completed rounds, 0–9, wrapping.

## Operation
- **Key path.** Each key passes through a `SYNC_STAGES` synchroniser, then a falling-edge detector. This produces `start_press` and `pause_press`, each high for exactly one cycle per physical press.
- **States:** IDLE, LOAD, RUNNING, PAUSED, OVER.
- **IDLE**
  - Outputs all 0.
  - `start_press` → LOAD.
  - `pause_press` and `game_finished` are ignored.
- **LOAD**
  - Lasts exactly one cycle, with `timer_load`=1.
  - Next state is always RUNNING. Keys are ignored in this cycle.
- **RUNNING**
  - Outputs: `timer_enable`=1, `game_active`=1.
  - `game_finished` (sampled high) → OVER.
  - Otherwise `pause_press` → PAUSED.
  - `start_press` is ignored.
- **PAUSED**
  - Outputs: `timer_enable`=0, `game_active`=1.
  - `pause_press` or `start_press` → RUNNING.
  - `game_finished` is ignored.
- **Entering OVER**
  - `round_count` increments by 1, wrapping 9→0.
  - The flash counter clears and `game_over_led` is set to 1.
- **OVER**
  - `game_over_led` toggles on each `one_second_pulse`.
  - The flash counter increments on each pulse. On the pulse that makes it equal `FLASH_SECONDS`, the next state is IDLE and `game_over_led` is 0.
  - `start_press` → LOAD immediately. The flash is abandoned and `game_over_led` is 0 from the next cycle.
- **Simultaneous events**
  - In RUNNING, `game_finished` beats `pause_press`.
  - In OVER, `start_press` beats a terminal `one_second_pulse`.
  - `start_press` and `pause_press` together in IDLE → LOAD.
- **Reset** (at any time, including mid-round)
  - State → IDLE.
  - `timer_load`, `timer_enable`, `game_active`, `game_over_led` → 0.
  - `round_count` → 0, flash counter → 0.
  - Synchronisers are filled with 1 (keys released). A key held through reset release does not produce a press.

## Timing
- Latency from a key falling edge at the pins to the press pulse is `SYNC_STAGES`+1 cycles.
- From `start_press` in IDLE:
  - `timer_load` is high on the next cycle (state LOAD).
  - `timer_enable` rises one cycle after that.
- All outputs are registered, with no combinational path from input to output.
- State changes take effect one cycle after the qualifying input.
- `game_finished` is sampled as a level. If it is still high when the FSM passes from OVER back to IDLE, the FSM does not re-enter OVER, because it is only observed in RUNNING.
- A `timer_load` issued from OVER clears `game_finished` downstream before RUNNING samples it. The downstream timer must deassert it in the same cycle it sees `timer_load`.

## Structure
- Package `round_pkg` holds:
  - The state enum: `ST_IDLE`, `ST_LOAD`, `ST_RUNNING`, `ST_PAUSED`, `ST_OVER`.
  - The `ROUND_CNT_MAX`=9 constant.
- One sub-module, `key_edge_detect`: synchroniser plus falling-edge detector, parameterised by `SYNC_STAGES`. It is instantiated twice.
- The FSM, flash counter and round counter live in `round_controller`.

## Test plan
- **Start a round.** After reset, press start.
  - `timer_load`=1 for exactly 1 cycle, 4 cycles after the edge (with `SYNC_STAGES`=2).
  - `timer_enable`=1 from the following cycle.
  - `load_value`=30.
- **Pause and resume.** While RUNNING, press pause → `timer_enable` goes 0 and `game_active` stays 1. Press pause again → `timer_enable`=1.
- **Finish and flash.** While RUNNING, assert `game_finished`.
  - `round_count` goes 0→1 and `game_over_led`=1.
  - The LED toggles on each of 3 `one_second_pulse` strobes, then the FSM returns to IDLE with the LED at 0.
- **Simultaneous finish and pause.** Assert `game_finished` and a pause press in the same cycle → OVER is entered, not PAUSED.
- **Restart during flash and counter wrap.**
  - Press start in OVER → LOAD immediately and the LED goes 0.
  - After 10 completed rounds, `round_count`=0.
- **Reset mid-round.** Assert `rst`=0 while RUNNING with `round_count`=5 → all outputs go 0 asynchronously. A key held low across reset release produces no `timer_load`.

Source files
------------

// File: rtl/round_pkg.sv
// Shared types and constants for the game-round sequencer.
package round_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUNNING,
    ST_PAUSED,
    ST_OVER
  } state_t;

  localparam logic [3:0] ROUND_CNT_MAX = 4'd9;

  function automatic logic [3:0] round_inc(
    input logic [3:0] c
  );
    return (c == ROUND_CNT_MAX) ? 4'd0 : c + 4'd1;
  endfunction

endpackage

// File: rtl/round_controller_key_edge_detect.sv
// Key synchroniser plus falling-edge detector, one pulse per press.
module key_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic last_q, last_d;
  logic armed_q, armed_d;
  logic press_q, press_d;
  logic key_s;

  assign key_s = sync_q[SYNC_STAGES-1];

  // Arm only once a genuine released level has crossed the chain,
  // so a key held through reset never reads as a press.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
    vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
    last_d  = key_s;
    armed_d = armed_q | (vld_q[SYNC_STAGES-1] & key_s);
    press_d = armed_q & last_q & ~key_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      vld_q   <= '0;
      last_q  <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: start, pause/resume, end-of-round flash
// and completed-round counting in front of the countdown timer.
module round_controller
  import round_pkg::*;
#(
  parameter int ROUND_SECONDS = 30,
  parameter int FLASH_SECONDS = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_pause_n,
  input  logic       one_second_pulse,
  input  logic       game_finished,
  output logic       timer_load,
  output logic [6:0] load_value,
  output logic       timer_enable,
  output logic       game_active,
  output logic       game_over_led,
  output logic [3:0] round_count
);

  localparam logic [3:0] FLASH_LAST = 4'(FLASH_SECONDS);

  state_t     state_q, state_d;
  logic       start_press, pause_press;
  logic       flash_done;
  logic [3:0] flash_q, flash_d;
  logic [3:0] round_q, round_d;
  logic       led_q, led_d;
  logic       tl_q, tl_d;
  logic       en_q, en_d;
  logic       act_q, act_d;

  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_start_n),
    .press (start_press)
  );

  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pause (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_pause_n),
    .press (pause_press)
  );

  assign flash_done = one_second_pulse
                    && (flash_q + 4'd1 == FLASH_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start_press) state_d = ST_LOAD;
      ST_LOAD:
        state_d = ST_RUNNING;
      ST_RUNNING:
        if (game_finished)    state_d = ST_OVER;
        else if (pause_press) state_d = ST_PAUSED;
      ST_PAUSED:
        if (pause_press || start_press) state_d = ST_RUNNING;
      ST_OVER:
        if (start_press)     state_d = ST_LOAD;
        else if (flash_done) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in the
  // same cycle as the state they describe.
  always_comb begin
    tl_d    = (state_d == ST_LOAD);
    en_d    = (state_d == ST_RUNNING);
    act_d   = (state_d == ST_RUNNING) || (state_d == ST_PAUSED);
    flash_d = flash_q;
    led_d   = led_q;
    round_d = round_q;
    if (state_q == ST_RUNNING && state_d == ST_OVER) begin
      round_d = round_inc(round_q);
      flash_d = '0;
      led_d   = 1'b1;
    end else if (state_q == ST_OVER && state_d != ST_OVER) begin
      flash_d = '0;
      led_d   = 1'b0;
    end else if (state_q == ST_OVER && one_second_pulse) begin
      flash_d = flash_q + 4'd1;
      led_d   = ~led_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tl_q    <= 1'b0;
      en_q    <= 1'b0;
      act_q   <= 1'b0;
      led_q   <= 1'b0;
      flash_q <= '0;
      round_q <= '0;
    end else begin
      tl_q    <= tl_d;
      en_q    <= en_d;
      act_q   <= act_d;
      led_q   <= led_d;
      flash_q <= flash_d;
      round_q <= round_d;
    end
  end

  assign timer_load    = tl_q;
  assign timer_enable  = en_q;
  assign game_active   = act_q;
  assign game_over_led = led_q;
  assign round_count   = round_q;
  assign load_value    = 7'(ROUND_SECONDS);

endmodule

// File: tb/tb_round_controller.sv
// Directed scenarios plus a randomized run against a behavioural model.
module tb_round_controller;

  localparam int FLASH = 3;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_OVER  = 4;

  logic       clk;
  logic       rst;
  logic       ks;
  logic       kp;
  logic       pulse;
  logic       gf;
  logic       timer_load;
  logic [6:0] load_value;
  logic       timer_enable;
  logic       game_active;
  logic       game_over_led;
  logic [3:0] round_count;

  int pass_cnt;
  int total_cnt;

  round_controller #(
    .ROUND_SECONDS (30),
    .FLASH_SECONDS (FLASH),
    .SYNC_STAGES   (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .key_start_n      (ks),
    .key_pause_n      (kp),
    .one_second_pulse (pulse),
    .game_finished    (gf),
    .timer_load       (timer_load),
    .load_value       (load_value),
    .timer_enable     (timer_enable),
    .game_active      (game_active),
    .game_over_led    (game_over_led),
    .round_count      (round_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ks = 1'b1; kp = 1'b1; pulse = 1'b0; gf = 1'b0;
    repeat (3) cyc();
    total_cnt++;
    if ({timer_load, timer_enable, game_active, game_over_led, round_count} !== 8'h00)
      $display("FAIL reset_outputs: got %b want 00000000",
        {timer_load, timer_enable, game_active, game_over_led, round_count});
    else pass_cnt++;
    total_cnt++;
    if (load_value !== 7'd30)
      $display("FAIL load_value: got %0d want 30", load_value);
    else pass_cnt++;
    rst = 1'b1;
    repeat (5) cyc();
  endtask

  task automatic test_start();
    ks = 1'b0;
    repeat (3) cyc();
    total_cnt++;
    if (timer_load !== 1'b0)
      $display("FAIL start_early: timer_load got %b want 0", timer_load);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({timer_load, timer_enable} !== 2'b10)
      $display("FAIL start_load: load/en got %b want 10", {timer_load, timer_enable});
    else pass_cnt++;
    cyc();
    total_cnt++;
    if ({timer_load, timer_enable, game_active} !== 3'b011)
      $display("FAIL start_run: load/en/act got %b want 011",
        {timer_load, timer_enable, game_active});
    else pass_cnt++;
    ks = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_pause_resume();
    kp = 1'b0;
    repeat (5) cyc();
    total_cnt++;
    if ({timer_enable, game_active} !== 2'b01)
      $display("FAIL pause: en/act got %b want 01", {timer_enable, game_active});
    else pass_cnt++;
    kp = 1'b1;
    repeat (4) cyc();
    kp = 1'b0;
    repeat (5) cyc();
    total_cnt++;
    if ({timer_enable, game_active} !== 2'b11)
      $display("FAIL resume: en/act got %b want 11", {timer_enable, game_active});
    else pass_cnt++;
    kp = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_finish_flash();
    gf = 1'b1;
    cyc();
    total_cnt++;
    if ({game_over_led, game_active, round_count} !== 6'b10_0001)
      $display("FAIL finish_enter: led/act/rc got %b want 100001",
        {game_over_led, game_active, round_count});
    else pass_cnt++;
    // game_finished stays high through the flash and back into IDLE
    for (int k = 1; k <= 3; k++) begin
      repeat (2) cyc();
      pulse = 1'b1;
      cyc();
      pulse = 1'b0;
      total_cnt++;
      if (game_over_led !== 1'((k % 2) == 0))
        $display("FAIL flash_toggle_%0d: led got %b want %b",
          k, game_over_led, 1'((k % 2) == 0));
      else pass_cnt++;
    end
    repeat (2) cyc();
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    repeat (2) cyc();
    total_cnt++;
    if ({game_over_led, game_active, timer_enable, round_count} !== 7'b000_0001)
      $display("FAIL flash_idle: led/act/en/rc got %b want 0000001",
        {game_over_led, game_active, timer_enable, round_count});
    else pass_cnt++;
    gf = 1'b0;
    cyc();
  endtask

  task automatic test_simultaneous();
    ks = 1'b0;
    repeat (6) cyc();
    ks = 1'b1;
    repeat (3) cyc();
    total_cnt++;
    if (timer_enable !== 1'b1)
      $display("FAIL sim_running: en got %b want 1", timer_enable);
    else pass_cnt++;
    kp = 1'b0;
    repeat (3) cyc();
    gf = 1'b1;
    cyc();
    gf = 1'b0;
    total_cnt++;
    if ({game_over_led, game_active, timer_enable, round_count} !== 7'b100_0010)
      $display("FAIL sim_finish_pause: led/act/en/rc got %b want 1000010",
        {game_over_led, game_active, timer_enable, round_count});
    else pass_cnt++;
    kp = 1'b1;
    repeat (3) cyc();
    total_cnt++;
    if (game_active !== 1'b0)
      $display("FAIL sim_not_paused: act got %b want 0", game_active);
    else pass_cnt++;
  endtask

  task automatic test_restart_and_wrap();
    for (int k = 0; k < 2; k++) begin
      pulse = 1'b1;
      cyc();
      pulse = 1'b0;
      cyc();
    end
    // start lands on the same cycle as the terminal pulse
    ks = 1'b0;
    repeat (3) cyc();
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    total_cnt++;
    if ({timer_load, game_over_led} !== 2'b10)
      $display("FAIL restart_load: load/led got %b want 10",
        {timer_load, game_over_led});
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (timer_enable !== 1'b1)
      $display("FAIL restart_run: en got %b want 1", timer_enable);
    else pass_cnt++;
    ks = 1'b1;
    repeat (3) cyc();
    for (int r = 3; r <= 15; r++) begin
      gf = 1'b1;
      cyc();
      gf = 1'b0;
      total_cnt++;
      if (round_count !== 4'(r % 10))
        $display("FAIL round_wrap_%0d: rc got %0d want %0d",
          r, round_count, r % 10);
      else pass_cnt++;
      ks = 1'b0;
      repeat (5) cyc();
      ks = 1'b1;
      repeat (3) cyc();
    end
  endtask

  task automatic test_reset_mid_round();
    logic seen_load;
    total_cnt++;
    if ({timer_enable, round_count} !== 5'b1_0101)
      $display("FAIL mid_pre: en/rc got %b want 10101",
        {timer_enable, round_count});
    else pass_cnt++;
    ks = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({timer_load, timer_enable, game_active, game_over_led, round_count} !== 8'h00)
      $display("FAIL mid_async: got %b want 00000000",
        {timer_load, timer_enable, game_active, game_over_led, round_count});
    else pass_cnt++;
    repeat (3) cyc();
    rst = 1'b1;
    seen_load = 1'b0;
    repeat (12) begin
      cyc();
      if (timer_load || game_active) seen_load = 1'b1;
    end
    total_cnt++;
    if (seen_load !== 1'b0)
      $display("FAIL held_key: load/act seen %b want 0", seen_load);
    else pass_cnt++;
    ks = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_random();
    logic hs[$];
    logic hp[$];
    int   ph;
    int   rounds;
    int   flashes;
    logic mled;
    logic sp;
    logic pp;
    logic [7:0] exp_v;
    logic [7:0] got_v;
    int   bad;
    rst = 1'b0; ks = 1'b1; kp = 1'b1; pulse = 1'b0; gf = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    ph = P_IDLE; rounds = 0; flashes = 0; mled = 1'b0;
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) ks = ~ks;
      if ($urandom_range(7) == 0) kp = ~kp;
      pulse = ($urandom_range(3) == 0);
      gf    = ($urandom_range(9) == 0);
      @(posedge clk);
      // a press reaches the sequencer four samples after the key falls
      sp = (hs.size() >= 4) && hs[$-3] && !hs[$-2];
      pp = (hp.size() >= 4) && hp[$-3] && !hp[$-2];
      case (ph)
        P_IDLE:  if (sp) ph = P_LOAD;
        P_LOAD:  ph = P_RUN;
        P_RUN: begin
          if (gf) begin
            ph = P_OVER;
            rounds = (rounds + 1) % 10;
            flashes = 0;
            mled = 1'b1;
          end else if (pp) ph = P_PAUSE;
        end
        P_PAUSE: if (sp || pp) ph = P_RUN;
        default: begin
          if (sp) begin
            ph = P_LOAD;
            mled = 1'b0;
          end else if (pulse) begin
            flashes++;
            if (flashes == FLASH) begin
              ph = P_IDLE;
              mled = 1'b0;
            end else mled = !mled;
          end
        end
      endcase
      hs.push_back(ks);
      hp.push_back(kp);
      #1;
      exp_v = {ph == P_LOAD, ph == P_RUN, ph == P_RUN || ph == P_PAUSE,
               mled, 4'(rounds)};
      got_v = {timer_load, timer_enable, game_active, game_over_led, round_count};
      total_cnt++;
      if (got_v !== exp_v) begin
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got %b want %b", n, got_v, exp_v);
        bad++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_start();
    test_pause_resume();
    test_finish_flash();
    test_simultaneous();
    test_restart_and_wrap();
    test_reset_mid_round();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
